aes_key_expand256: RTL and testbench

AES_KEY_EXPAND256 -- requirements
Module: aes_key_expand256

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sbox.sv | 49 ++++
 rtl/aes_key_expand256.sv | 115 +++++++++++
 tb/tb_aes_key_expand256.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule FSM states, schedule sizes and
// the GF(2^8) doubling used for round constants.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_e;

    localparam int NUM_ROUND_KEYS = 15;
    localparam int LAST_IDX       = 14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform, computed rather than tabulated.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b,
                                        input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = gf_inv(in_i);
        out_o = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
              ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand256.sv
// AES-256 key schedule: produces one 128-bit round key per cycle
// into a 15-entry register array read directly by the cipher.
module aes_key_expand256
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic [127:0] round_key [14:0],
    output logic         keys_valid,
    output logic         busy
);

    ks_state_e    state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         kv_q, kv_d;
    logic [127:0] rk_q [14:0];
    logic         load_en;
    logic         exp_en;

    logic [127:0] prev_key;
    logic [127:0] prev2_key;
    logic [31:0]  last_w;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t_w;
    logic [31:0]  nw0, nw1, nw2, nw3;

    assign prev_key  = rk_q[idx_q - 4'd1];
    assign prev2_key = rk_q[idx_q - 4'd2];
    assign last_w    = prev_key[31:0];

    // Even entries start a new 256-bit block and need RotWord plus rcon.
    assign sub_in = idx_q[0] ? last_w
                             : {last_w[23:0], last_w[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (sub_in[8*b +: 8]),
            .out_o (sub_out[8*b +: 8])
        );
    end

    assign t_w = idx_q[0] ? sub_out
                          : sub_out ^ {rcon_q, 24'h000000};

    assign nw0 = prev2_key[127:96] ^ t_w;
    assign nw1 = prev2_key[95:64]  ^ nw0;
    assign nw2 = prev2_key[63:32]  ^ nw1;
    assign nw3 = prev2_key[31:0]   ^ nw2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            kv_q    <= kv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        kv_d    = kv_q;
        load_en = 1'b0;
        exp_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_en = 1'b1;
                    idx_d   = 4'd2;
                    rcon_d  = RCON_INIT;
                    kv_d    = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                exp_en = 1'b1;
                idx_d  = idx_q + 4'd1;
                if (!idx_q[0]) rcon_d = xtime(rcon_q);
                if (idx_q == 4'(LAST_IDX)) begin
                    state_d = DONE;
                    kv_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
                rk_q[i] <= 128'h0;
            end
        end else if (load_en) begin
            rk_q[0] <= key_in[255:128];
            rk_q[1] <= key_in[127:0];
        end else if (exp_en) begin
            rk_q[idx_q] <= {nw0, nw1, nw2, nw3};
        end
    end

    assign round_key  = rk_q;
    assign keys_valid = kv_q;
    assign busy       = (state_q == EXPAND);

endmodule

// File: tb/tb_aes_key_expand256.sv
// Randomized bench for aes_key_expand256 with a word-level FIPS-197
// key-schedule model and a cycle-by-cycle output scoreboard.
module tb_aes_key_expand256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic [127:0] rk [14:0];
    logic         keys_valid;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_RK2   = 128'h62636363626363636263636362636363;

    always #5 clk = ~clk;

    aes_key_expand256 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .round_key  (rk),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    logic [7:0]   sb [256];
    logic [7:0]   rcl [7] = '{8'h01, 8'h02, 8'h04, 8'h08,
                              8'h10, 8'h20, 8'h40};
    logic [127:0] calc [15];
    logic [127:0] full_m [15];
    logic [127:0] m_rk [15];
    int           cnt = 0;
    bit           active = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                sb[x][i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                         ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcl[i / 8 - 1], 24'h0};
            else if (i % 8 == 4)
                t = subw(t);
            w[i] = w[i - 8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            calc[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Schedule model: counts edges since the accepted start.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 15; j++) m_rk[j] = 128'h0;
            active = 1'b0;
            cnt    = 0;
        end else if (start && !(active && cnt < 13)) begin
            expand(key_in);
            full_m  = calc;
            m_rk[0] = full_m[0];
            m_rk[1] = full_m[1];
            active  = 1'b1;
            cnt     = 0;
        end else if (active && cnt < 13) begin
            cnt++;
            m_rk[cnt + 1] = full_m[cnt + 1];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("keys_valid", 128'(keys_valid),
                128'(active && cnt >= 13));
            chk("busy", 128'(busy), 128'(active && cnt < 13));
            for (int j = 0; j < 15; j++)
                chk($sformatf("round_key[%0d]", j), rk[j], m_rk[j]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [255:0] k);
        key_in = k;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
    endtask

    task automatic wait_valid(input int already, input string nm);
        int n = already;
        while (!keys_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk(nm, 128'(n), 128'd13);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        chk("sbox[00]", 128'(sb[0]), 128'h63);
        chk("sbox[53]", 128'(sb[8'h53]), 128'hed);
        expand(KEY_A3);
        chk("model_a3_rk2", calc[2], A3_RK2);
        chk("model_a3_rk14", calc[14], A3_RK14);
        expand('0);
        chk("model_zero_rk2", calc[2], Z_RK2);

        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        pulse_start(KEY_A3);
        wait_valid(0, "a3_latency");
        chk("a3_rk2", rk[2], A3_RK2);
        chk("a3_rk14", rk[14], A3_RK14);

        pulse_start(KEY_A3);
        tick(4);
        key_in = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(5, "busy_start_latency");
        chk("busy_start_rk14", rk[14], A3_RK14);

        pulse_start({$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom});
        tick(7);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("abort_valid", 128'(keys_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_rk14", rk[14], 128'h0);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (keys_valid) chk("abort_no_valid", 128'(keys_valid), 128'd0);
        end

        pulse_start(KEY_A3);
        wait_valid(0, "a3_again_latency");
        pulse_start('0);
        chk("restart_valid_drop", 128'(keys_valid), 128'd0);
        tick(13);
        chk("restart_valid", 128'(keys_valid), 128'd1);
        chk("restart_rk2", rk[2], Z_RK2);

        tick(100);
        chk("hold_valid", 128'(keys_valid), 128'd1);
        chk("hold_rk2", rk[2], Z_RK2);

        for (int it = 0; it < 250; it++) begin
            int r = $urandom_range(0, 99);
            key_in = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
            if (r < 20) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end else if (r < 24) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end else begin
                tick($urandom_range(1, 8));
            end
        end
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
